req_issuer: RTL and testbench

REQ_ISSUER -- requirements
Module: req_issuer

---
 rtl/arb_pkg.sv | 19 +
 rtl/req_chan.sv | 65 ++++++
 rtl/req_issuer.sv | 54 +++++
 tb/tb_req_issuer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared defaults and width helper for the request issuer and its paired arbiter.
package arb_pkg;

    localparam int N_DEF     = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_DEC  = 2'b01,
        CNT_INC  = 2'b10,
        CNT_BOTH = 2'b11
    } cnt_op_e;

    // Width needed to hold a pending count from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/req_chan.sv
// One request channel: pending-event counter, in-flight tracking and served/drop pulses.
module req_chan
    import arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          event_in,
    input  logic          grant,
    input  logic          stall,
    output logic          request,
    output logic          infl,
    output logic          served,
    output logic          drop,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          infl_r;
    logic          served_r;
    logic          drop_r;
    logic          valid_grant_s;
    logic          accept_s;
    cnt_op_e       op_s;

    assign request = (cnt_r != {CW{1'b0}}) & ~infl_r;
    assign infl    = infl_r;
    assign served  = served_r;
    assign drop    = drop_r;
    assign cnt     = cnt_r;

    // A grant only counts when it matches a latched request; it also frees a slot for a same-cycle event.
    always_comb begin
        valid_grant_s = grant & infl_r;
        accept_s      = event_in & ((cnt_r < FULL) | valid_grant_s);
        op_s          = cnt_op_e'({accept_s, valid_grant_s});
        case (op_s)
            CNT_INC: cnt_next_s = cnt_r + ONE;
            CNT_DEC: cnt_next_s = cnt_r - ONE;
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Channel state; infl ends high when a grant and a new latch coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= {CW{1'b0}};
            infl_r   <= 1'b0;
            served_r <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            infl_r   <= (infl_r & ~valid_grant_s) | (request & ~stall);
            served_r <= valid_grant_s;
            drop_r   <= event_in & ~accept_s;
        end
    end

endmodule

// File: rtl/req_issuer.sv
// N independent request channels feeding an arbiter, with a sticky spurious-grant flag.
module req_issuer
    import arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N-1:0]                     event_in,
    output logic [N-1:0]                     request,
    input  logic [N-1:0]                     grant,
    input  logic                             stall,
    output logic [N-1:0]                     served,
    output logic [N-1:0]                     drop,
    output logic                             grant_err,
    output logic [N*cnt_width(DEPTH)-1:0]    pend_cnt
);

    localparam int CW = cnt_width(DEPTH);

    logic [N-1:0] infl_s;
    logic         grant_err_r;

    assign grant_err = grant_err_r;

    for (genvar i = 0; i < N; i++) begin : g_chan
        req_chan #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .event_in (event_in[i]),
            .grant    (grant[i]),
            .stall    (stall),
            .request  (request[i]),
            .infl     (infl_s[i]),
            .served   (served[i]),
            .drop     (drop[i]),
            .cnt      (pend_cnt[i*CW +: CW])
        );
    end

    // Any grant landing on a channel with nothing in flight latches the error until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_err_r <= 1'b0;
        end else begin
            grant_err_r <= grant_err_r | (|(grant & ~infl_s));
        end
    end

endmodule

// File: tb/tb_req_issuer.sv
// Bench pairing req_issuer with a small sequential arbiter; expectations flow through a scoreboard queue.
module tb_req_issuer;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic            clk;
    logic            reset;
    logic [N-1:0]    event_in;
    logic [N-1:0]    request;
    logic [N-1:0]    grant;
    logic            stall;
    logic [N-1:0]    served;
    logic [N-1:0]    drop;
    logic            grant_err;
    logic [N*CW-1:0] pend_cnt;

    // Manual override lets the bench drive grant/stall directly for corner cases.
    logic            manual;
    logic [N-1:0]    man_grant;
    logic            man_stall;
    logic [N-1:0]    arb_l;
    logic [N-1:0]    arb_g;
    logic            arb_stall;

    int n_checks = 0;
    int n_errors = 0;
    int srv_cnt [N];
    int drp_cnt [N];
    int m_cnt   [N];
    bit m_infl  [N];
    bit m_err;

    typedef struct packed {
        logic [N-1:0]    served;
        logic [N-1:0]    drop;
        logic [N-1:0]    request;
        logic [N*CW-1:0] pend;
        logic            err;
    } exp_t;

    exp_t sb[$];

    req_issuer #(.N(N), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .event_in  (event_in),
        .request   (request),
        .grant     (grant),
        .stall     (stall),
        .served    (served),
        .drop      (drop),
        .grant_err (grant_err),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter: latches the request vector when idle, then grants one channel per cycle lowest first.
    always_ff @(posedge clk) begin
        if (reset || manual) begin
            arb_l <= 8'h00;
            arb_g <= 8'h00;
        end else if (!arb_stall && request != 8'h00) begin
            arb_g <= request & (~request + 8'd1);
            arb_l <= request & (request - 8'd1);
        end else if (arb_l != 8'h00) begin
            arb_g <= arb_l & (~arb_l + 8'd1);
            arb_l <= arb_l & (arb_l - 8'd1);
        end else begin
            arb_g <= 8'h00;
        end
    end

    assign arb_stall = |arb_l;
    assign grant     = manual ? man_grant : arb_g;
    assign stall     = manual ? man_stall : arb_stall;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, predict next outputs, advance, compare.
    task automatic step(input logic [N-1:0] ev, input logic rst);
        exp_t e;
        logic [N-1:0] g;
        logic st;
        bit vg, rq, acc;
        event_in = ev;
        reset    = rst;
        #1;
        g  = grant;
        st = stall;
        e  = '0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  = 0;
                m_infl[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                vg  = g[i] && m_infl[i];
                rq  = (m_cnt[i] != 0) && !m_infl[i];
                acc = ev[i] && ((m_cnt[i] < D) || vg);
                e.drop[i]   = ev[i] && !acc;
                e.served[i] = vg;
                if (g[i] && !m_infl[i]) m_err = 1'b1;
                m_cnt[i]  = m_cnt[i] + int'(acc) - int'(vg);
                m_infl[i] = (m_infl[i] && !vg) || (rq && !st);
            end
        end
        for (int i = 0; i < N; i++) begin
            e.request[i]       = (m_cnt[i] != 0) && !m_infl[i];
            e.pend[i*CW +: CW] = 3'(m_cnt[i]);
        end
        e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("served",    32'(served),    32'(e.served));
        chk("drop",      32'(drop),      32'(e.drop));
        chk("request",   32'(request),   32'(e.request));
        chk("pend_cnt",  32'(pend_cnt),  32'(e.pend));
        chk("grant_err", 32'(grant_err), 32'(e.err));
        for (int i = 0; i < N; i++) begin
            srv_cnt[i] += int'(served[i]);
            drp_cnt[i] += int'(drop[i]);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            srv_cnt[i] = 0;
            drp_cnt[i] = 0;
        end
    endtask

    initial begin
        manual    = 1'b0;
        man_grant = 8'h00;
        man_stall = 1'b0;
        reset     = 1'b1;
        event_in  = 8'h00;
        clear_counts();
        @(posedge clk);
        #1;
        step(8'h00, 1'b1);
        step(8'h5A, 1'b1);
        chk("rst_pend", 32'(pend_cnt), 32'h0);

        // Single event on channel 3.
        step(8'h08, 1'b0);
        chk("t034_req", 32'(request), 32'h08);
        step(8'h00, 1'b0);
        chk("t034_grant", 32'(grant), 32'h08);
        step(8'h00, 1'b0);
        chk("t034_served", 32'(served), 32'h08);
        chk("t034_cnt", 32'(pend_cnt), 32'h0);
        step(8'h00, 1'b0);

        // All channels at once: grants in order 0..7 with stall high for seven of them.
        clear_counts();
        step(8'hFF, 1'b0);
        step(8'h00, 1'b0);
        for (int k = 0; k < N; k++) begin
            chk("t035_grant", 32'(grant), 32'(8'h01 << k));
            chk("t035_stall", 32'(stall), (k < 7) ? 32'h1 : 32'h0);
            chk("t035_noreq", 32'(request), 32'h0);
            step(8'h00, 1'b0);
        end
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        for (int i = 0; i < N; i++) chk("t035_srv_once", 32'(srv_cnt[i]), 32'h1);

        // Overflow on channel 0 with the arbiter held busy.
        clear_counts();
        manual    = 1'b1;
        man_stall = 1'b1;
        man_grant = 8'h00;
        for (int k = 0; k < 6; k++) step(8'h01, 1'b0);
        step(8'h00, 1'b0);
        chk("t036_cnt", 32'(pend_cnt[2:0]), 32'h4);
        chk("t036_drops", 32'(drp_cnt[0]), 32'h2);

        // Full channel: event coincides with a valid grant.
        man_stall = 1'b0;
        step(8'h00, 1'b0);
        man_stall = 1'b1;
        man_grant = 8'h01;
        step(8'h01, 1'b0);
        man_grant = 8'h00;
        chk("t037_cnt", 32'(pend_cnt[2:0]), 32'h4);
        chk("t037_drop", 32'(drop), 32'h0);
        chk("t037_served", 32'(served), 32'h01);
        step(8'h00, 1'b0);
        chk("t037_srv_once", 32'(srv_cnt[0]), 32'h1);

        // Spurious grant on channel 5, then reset.
        man_grant = 8'h20;
        step(8'h00, 1'b0);
        man_grant = 8'h00;
        chk("t038_err", 32'(grant_err), 32'h1);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("t038_sticky", 32'(grant_err), 32'h1);
        chk("t038_cnt5", 32'(pend_cnt[17:15]), 32'h0);
        step(8'h00, 1'b1);
        chk("t038_rst_all", 32'({request, served, drop, grant_err}), 32'h0);
        chk("t038_rst_pend", 32'(pend_cnt), 32'h0);
        manual    = 1'b0;
        man_stall = 1'b0;

        // Reset while channels 2 and 4 are in flight, then resume.
        clear_counts();
        step(8'h14, 1'b0);
        step(8'h00, 1'b0);
        chk("t039_grant", 32'(grant), 32'h04);
        step(8'h00, 1'b1);
        for (int k = 0; k < 4; k++) step(8'h00, 1'b0);
        chk("t039_nosrv", 32'(srv_cnt[2] + srv_cnt[4]), 32'h0);
        chk("t039_pend", 32'(pend_cnt), 32'h0);
        step(8'h02, 1'b0);
        for (int k = 0; k < 4; k++) step(8'h00, 1'b0);
        chk("t039_resume", 32'(srv_cnt[1]), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
